uart_rx: RTL and testbench
==========================

Name: uart_rx

Overview:
UART receive front end: the counterpart of the TX serializer/frame path.
- Oversamples an asynchronous serial line and detects the start bit.
- Recovers FRAME_WIDTH data bits, LSB first, plus optional parity and one stop bit.
- Presents the recovered byte in parallel with a one-cycle valid strobe and per-frame error flags.
- Sits between the RX pad and the system-side RX consumer (FIFO / register block).

Parameters:
FRAME_WIDTH, 8, number of data bits per frame.
PRESCALE_WIDTH, 6, width of the prescale input and the edge counter; must hold the value 32.

Ports:
clk  input  1  system clock, runs at prescale x baud rate.
reset  input  1  asynchronous, active-low reset.
rx_in  input  1  serial line; idle high; asynchronous to clk.
prescale  input  PRESCALE_WIDTH  oversampling ratio; legal values 8, 16, 32; sampled only in IDLE.
par_en  input  1  1 = parity bit present after the data bits.
par_typ  input  1  0 = even parity, 1 = odd parity; sampled only in IDLE.
p_data  output  FRAME_WIDTH  last good received byte; holds until the next good frame.
data_valid  output  1  one-cycle pulse when p_data is updated.
par_err  output  1  one-cycle pulse: parity mismatch in the completed frame.
stp_err  output  1  one-cycle pulse: stop bit sampled low.

Behaviour:
- Reset values: p_data=0, data_valid=0, par_err=0, stp_err=0, FSM=IDLE, counters=0.
- Synchronizer: rx_in passes a 2-flop synchronizer with reset value 1. All timing below refers to the synchronized bit rx_s, which is 2 clk behind rx_in.
- Counters:
  - edge_cnt runs 0..prescale-1 within each bit period.
  - bit_cnt counts data bits 0..FRAME_WIDTH-1.
- Sampling: 3 samples at edge_cnt = prescale/2-1, prescale/2, prescale/2+1. Bit value = majority of the three. The sampled bit is valid from edge_cnt = prescale/2+2 onward.
- FSM states and transitions:
  - IDLE: on rx_s=0 go to START with edge_cnt=1 (the detecting cycle counts as edge 0). Latch prescale, par_en, par_typ.
  - START: at edge_cnt=prescale-1, a majority of 1 is a glitch: return to IDLE with no flags. Otherwise go to DATA.
  - DATA: shift the sampled bit into a shift register, MSB-in / right-shift, so the first received bit lands at bit 0. After bit FRAME_WIDTH-1 ends, go to PARITY if par_en else STOP.
  - PARITY: at the end of the bit, compute the error. Even: XOR of data XOR parity bit must be 0. Odd: must be 1. Store the error; go to STOP.
  - STOP: at the end of the bit, stop error if the sample is 0. Go to DONE.
  - DONE: lasts exactly 1 cycle.
    - Always pulse par_err/stp_err per the stored errors.
    - Pulse data_valid and load p_data only if both errors are 0.
    - Next state: START with edge_cnt=1 if rx_s=0 (back-to-back frames), else IDLE.
- Latency: data_valid rises 1 clk after the final stop-bit edge. That is (1+FRAME_WIDTH+par_en+1)*prescale + 1 clks after rx_s first goes low.
- Both errors in one frame: par_err and stp_err pulse together, no data_valid.
- A line held low (break) gives a frame of zeros with stp_err. The FSM then re-enters START only when rx_s is high for at least one cycle and then goes low.
- Reset mid-frame: immediate return to the reset values; no partial pulse.
- Changing prescale, par_en or par_typ mid-frame has no effect until the next IDLE.
- An illegal prescale value gives unspecified sampling but must not hang the FSM; edge_cnt still wraps at prescale-1.

Decomposition:
- Package uart_pkg:
  - FSM state localparams: IDLE, START, DATA, PARITY, STOP, DONE.
  - Legal prescale constants: PRESCALE_8, PRESCALE_16, PRESCALE_32.
  - Parity type constants: PAR_EVEN, PAR_ODD.
- Sub-module uart_rx_sampler: holds the 3-sample registers and the majority vote, keyed by edge_cnt and prescale. Outputs sampled_bit.
- FSM, counters and the output register stay in uart_rx.

Test Plan:
1. prescale=8, par_en=0, send 0xA5 (bits 1,0,1,0,0,1,0,1 LSB first) -> exactly one data_valid pulse, p_data=0xA5, no error pulses, latency 10*8+1 clks after rx_s falls.
2. prescale=16, par_en=1, par_typ=0, send 0x3C with parity 0 -> data_valid, p_data=0x3C. Same byte with parity bit 1 -> par_err pulse, no data_valid, p_data stays 0x3C.
3. prescale=32, par_en=1, par_typ=1, send 0x00 with parity 1 and stop bit 0 -> stp_err pulse only, no data_valid. Then 0xFF with parity 1 and a good stop -> data_valid, p_data=0xFF.
4. prescale=16, rx_in low for 5 clks then high -> no output pulse, FSM back in IDLE. A valid 0x55 frame right after -> data_valid, p_data=0x55.
5. prescale=8, frames 0x12 and 0x34 back to back with no idle gap -> two data_valid pulses exactly 80 clks apart, p_data=0x12 then 0x34.
6. prescale=16, assert reset during data bit 3 of frame 0xC3, release, send 0x81 -> all outputs 0 during reset, then a single data_valid with p_data=0x81.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared types and constants for the UART receive path.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package uart_pkg;

  // Receiver frame-tracking states.
  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4,
    DONE   = 3'd5
  } rx_state_e;

  // Supported oversampling ratios.
  localparam int unsigned PRESCALE_8  = 8;
  localparam int unsigned PRESCALE_16 = 16;
  localparam int unsigned PRESCALE_32 = 32;

  // Parity type encoding on par_typ.
  localparam logic PAR_EVEN = 1'b0;
  localparam logic PAR_ODD  = 1'b1;

endpackage

// File: rtl/uart_rx_sampler.sv
// Mid-bit 3-sample majority voter for the oversampled serial line.
// Latency: sampled_bit is valid from edge_cnt = prescale/2+2 of the current bit.
// Backpressure: none; samples every bit period unconditionally.
// Ports: clk/reset (async active-low); rx_s synchronized line; edge_cnt
//        position within the bit; prescale latched ratio; sampled_bit vote.
module uart_rx_sampler #(
  parameter int PRESCALE_WIDTH = 6
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      rx_s,
  input  logic [PRESCALE_WIDTH-1:0] edge_cnt,
  input  logic [PRESCALE_WIDTH-1:0] prescale,
  output logic                      sampled_bit
);

  localparam logic [PRESCALE_WIDTH-1:0] ONE = 1;

  logic [PRESCALE_WIDTH-1:0] half;
  logic [2:0]                smp_q, smp_d;

  always_comb begin
    half  = prescale >> 1;
    smp_d = smp_q;
    // Three consecutive samples centred on the middle of the bit.
    if (edge_cnt == half - ONE) smp_d[0] = rx_s;
    if (edge_cnt == half)       smp_d[1] = rx_s;
    if (edge_cnt == half + ONE) smp_d[2] = rx_s;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) smp_q <= 3'b111;
    else        smp_q <= smp_d;
  end

  assign sampled_bit = (smp_q[0] & smp_q[1]) | (smp_q[0] & smp_q[2]) | (smp_q[1] & smp_q[2]);

endmodule

// File: rtl/uart_rx.sv
// UART receiver: start detect, LSB-first data recovery, optional parity, one stop bit.
// Latency: data_valid (1+FRAME_WIDTH+par_en+1)*prescale+1 clk after the synchronized line falls.
// Backpressure: none; p_data/data_valid and error strobes are one-cycle pulses the consumer must take.
// Ports: clk, reset (async active-low); rx_in serial line; prescale/par_en/par_typ
//        frame config (latched in IDLE); p_data, data_valid, par_err, stp_err results.
module uart_rx
  import uart_pkg::*;
#(
  parameter int FRAME_WIDTH    = 8,
  parameter int PRESCALE_WIDTH = 6
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      rx_in,
  input  logic [PRESCALE_WIDTH-1:0] prescale,
  input  logic                      par_en,
  input  logic                      par_typ,
  output logic [FRAME_WIDTH-1:0]    p_data,
  output logic                      data_valid,
  output logic                      par_err,
  output logic                      stp_err
);

  localparam int                        BW       = $clog2(FRAME_WIDTH);
  localparam logic [BW-1:0]             LAST_BIT = BW'(FRAME_WIDTH - 1);
  localparam logic [PRESCALE_WIDTH-1:0] ONE      = 1;

  rx_state_e                 state_q, state_d;
  logic [1:0]                sync_q, sync_d;
  logic [PRESCALE_WIDTH-1:0] edge_cnt_q, edge_cnt_d;
  logic [PRESCALE_WIDTH-1:0] prescale_q, prescale_d;
  logic [BW-1:0]             bit_cnt_q, bit_cnt_d;
  logic                      par_en_q, par_en_d;
  logic                      par_typ_q, par_typ_d;
  logic [FRAME_WIDTH-1:0]    shift_q, shift_d;
  logic [FRAME_WIDTH-1:0]    p_data_q, p_data_d;
  logic                      par_flag_q, par_flag_d;
  logic                      stp_flag_q, stp_flag_d;
  logic                      brk_q, brk_d;
  logic                      data_valid_q, data_valid_d;
  logic                      par_err_q, par_err_d;
  logic                      stp_err_q, stp_err_d;

  logic rx_s;
  logic bit_end;
  logic sampled_bit;

  assign rx_s    = sync_q[1];
  assign bit_end = (edge_cnt_q == prescale_q - ONE);

  uart_rx_sampler #(
    .PRESCALE_WIDTH(PRESCALE_WIDTH)
  ) u_sampler (
    .clk        (clk),
    .reset      (reset),
    .rx_s       (rx_s),
    .edge_cnt   (edge_cnt_q),
    .prescale   (prescale_q),
    .sampled_bit(sampled_bit)
  );

  always_comb begin
    sync_d       = {sync_q[0], rx_in};
    state_d      = state_q;
    edge_cnt_d   = bit_end ? '0 : edge_cnt_q + ONE;
    prescale_d   = prescale_q;
    bit_cnt_d    = bit_cnt_q;
    par_en_d     = par_en_q;
    par_typ_d    = par_typ_q;
    shift_d      = shift_q;
    p_data_d     = p_data_q;
    par_flag_d   = par_flag_q;
    stp_flag_d   = stp_flag_q;
    brk_d        = brk_q;
    data_valid_d = 1'b0;
    par_err_d    = 1'b0;
    stp_err_d    = 1'b0;

    case (state_q)
      IDLE: begin
        edge_cnt_d = '0;
        bit_cnt_d  = '0;
        // After a framing error the line must return high before a new start is armed.
        if (rx_s) brk_d = 1'b0;
        if (!rx_s && !brk_q) begin
          state_d    = START;
          edge_cnt_d = ONE;
          prescale_d = prescale;
          par_en_d   = par_en;
          par_typ_d  = par_typ;
          par_flag_d = 1'b0;
          stp_flag_d = 1'b0;
        end
      end
      START: begin
        if (bit_end) state_d = sampled_bit ? IDLE : DATA;
      end
      DATA: begin
        if (bit_end) begin
          shift_d   = {sampled_bit, shift_q[FRAME_WIDTH-1:1]};
          bit_cnt_d = bit_cnt_q + 1'b1;
          if (bit_cnt_q == LAST_BIT) begin
            bit_cnt_d = '0;
            state_d   = par_en_q ? PARITY : STOP;
          end
        end
      end
      PARITY: begin
        if (bit_end) begin
          par_flag_d = (^shift_q) ^ sampled_bit ^ (par_typ_q == PAR_ODD);
          state_d    = STOP;
        end
      end
      STOP: begin
        if (bit_end) begin
          stp_flag_d = ~sampled_bit;
          brk_d      = ~sampled_bit;
          state_d    = DONE;
        end
      end
      DONE: begin
        par_err_d  = par_flag_q;
        stp_err_d  = stp_flag_q;
        edge_cnt_d = '0;
        if (!par_flag_q && !stp_flag_q) begin
          data_valid_d = 1'b1;
          p_data_d     = shift_q;
        end
        // This cycle is edge 0 of a back-to-back start bit when the line is already low.
        if (!rx_s && !stp_flag_q) begin
          state_d    = START;
          edge_cnt_d = ONE;
          par_flag_d = 1'b0;
          stp_flag_d = 1'b0;
        end else begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d    = IDLE;
        edge_cnt_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= IDLE;
      sync_q       <= 2'b11;
      edge_cnt_q   <= '0;
      prescale_q   <= PRESCALE_WIDTH'(PRESCALE_16);
      bit_cnt_q    <= '0;
      par_en_q     <= 1'b0;
      par_typ_q    <= 1'b0;
      shift_q      <= '0;
      p_data_q     <= '0;
      par_flag_q   <= 1'b0;
      stp_flag_q   <= 1'b0;
      brk_q        <= 1'b0;
      data_valid_q <= 1'b0;
      par_err_q    <= 1'b0;
      stp_err_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      sync_q       <= sync_d;
      edge_cnt_q   <= edge_cnt_d;
      prescale_q   <= prescale_d;
      bit_cnt_q    <= bit_cnt_d;
      par_en_q     <= par_en_d;
      par_typ_q    <= par_typ_d;
      shift_q      <= shift_d;
      p_data_q     <= p_data_d;
      par_flag_q   <= par_flag_d;
      stp_flag_q   <= stp_flag_d;
      brk_q        <= brk_d;
      data_valid_q <= data_valid_d;
      par_err_q    <= par_err_d;
      stp_err_q    <= stp_err_d;
    end
  end

  assign p_data     = p_data_q;
  assign data_valid = data_valid_q;
  assign par_err    = par_err_q;
  assign stp_err    = stp_err_q;

endmodule

// File: tb/tb_uart_rx.sv
// Bench for uart_rx: frame-level expected-event model plus per-cycle compare.
// Latency: n/a.
// Backpressure: n/a.
module tb_uart_rx;
  import uart_pkg::*;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       rx_in = 1'b1;
  logic [5:0] prescale = 6'd8;
  logic       par_en = 1'b0;
  logic       par_typ = 1'b0;
  logic [7:0] p_data;
  logic       data_valid, par_err, stp_err;

  uart_rx #(.FRAME_WIDTH(8), .PRESCALE_WIDTH(6)) dut (
    .clk(clk), .reset(reset), .rx_in(rx_in), .prescale(prescale),
    .par_en(par_en), .par_typ(par_typ), .p_data(p_data),
    .data_valid(data_valid), .par_err(par_err), .stp_err(stp_err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int         cyc;
    logic       dv;
    logic       pe;
    logic       se;
    logic [7:0] data;
  } ev_t;

  ev_t        q[$];
  logic [7:0] exp_pdata = 8'h00;
  int total = 0;
  int bad = 0;
  int dv_cnt = 0, pe_cnt = 0, se_cnt = 0;
  int last_dv_cyc = 0, prev_dv_cyc = 0;
  logic [7:0] last_dv_data = 8'h00, prev_dv_data = 8'h00;
  int last_d = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (cyc %0d)", nm, act, exp, cyc);
    end
  endtask

  // Per-cycle compare against the expected-event queue.
  always @(negedge clk) begin
    logic e_dv, e_pe, e_se;
    ev_t  e;
    e_dv = 1'b0; e_pe = 1'b0; e_se = 1'b0;
    if (!reset) begin
      q.delete();
      exp_pdata = 8'h00;
    end else if (q.size() > 0 && q[0].cyc == cyc) begin
      e = q.pop_front();
      e_dv = e.dv; e_pe = e.pe; e_se = e.se;
      if (e.dv) exp_pdata = e.data;
    end
    chk("data_valid", data_valid, e_dv);
    chk("par_err", par_err, e_pe);
    chk("stp_err", stp_err, e_se);
    chk("p_data", p_data, exp_pdata);
    if (data_valid === 1'b1) begin
      dv_cnt++;
      prev_dv_cyc  = last_dv_cyc;
      last_dv_cyc  = cyc;
      prev_dv_data = last_dv_data;
      last_dv_data = p_data;
    end
    if (par_err === 1'b1) pe_cnt++;
    if (stp_err === 1'b1) se_cnt++;
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic drive_bit(input logic b, input int n);
    rx_in = b;
    tick(n);
  endtask

  task automatic idle(input int n);
    drive_bit(1'b1, n);
  endtask

  function automatic logic good_par(input logic [7:0] d, input logic pt);
    return (^d) ^ pt;
  endfunction

  // Drives one complete frame and queues the outcome the rules demand.
  task automatic send_frame(input logic [7:0] data, input int p, input logic pe,
                            input logic pt, input logic pbit, input logic sbit);
    int  n;
    ev_t e;
    prescale = p[5:0];
    par_en   = pe;
    par_typ  = pt;
    n        = 1 + 8 + (pe ? 1 : 0) + 1;
    last_d   = cyc;
    // rx_s lags rx_in by 2 clk; outputs register one clk after the frame ends.
    e.cyc  = cyc + 3 + n * p;
    e.pe   = pe && (((^data) ^ pbit) != pt);
    e.se   = !sbit;
    e.dv   = !e.pe && !e.se;
    e.data = data;
    q.push_back(e);
    drive_bit(1'b0, p);
    // Config pins are don't-care once the frame has started.
    prescale = 6'($urandom);
    par_en   = 1'($urandom);
    par_typ  = 1'($urandom);
    for (int i = 0; i < 8; i++) drive_bit(data[i], p);
    if (pe) drive_bit(pbit, p);
    drive_bit(sbit, p);
  endtask

  initial begin
    int d0, p0, s0;
    int p, pp;
    logic pe, pt, ppe, ppt, prev_stop_ok;
    logic [7:0] d;

    tick(3);
    chk("reset_pdata", p_data, 8'h00);
    chk("reset_dv", data_valid, 1'b0);
    reset = 1'b1;
    idle(10);

    // 1: 0xA5 at prescale 8, no parity.
    d0 = dv_cnt; p0 = pe_cnt; s0 = se_cnt;
    send_frame(8'hA5, PRESCALE_8, 1'b0, PAR_EVEN, 1'b0, 1'b1);
    idle(20);
    chk("t1_dv_count", dv_cnt - d0, 1);
    chk("t1_pdata", p_data, 8'hA5);
    chk("t1_latency", last_dv_cyc - (last_d + 2), 81);
    chk("t1_errs", (pe_cnt - p0) + (se_cnt - s0), 0);

    // 2: even parity, good then bad parity bit.
    d0 = dv_cnt; p0 = pe_cnt;
    send_frame(8'h3C, PRESCALE_16, 1'b1, PAR_EVEN, 1'b0, 1'b1);
    idle(20);
    chk("t2_dv_good", dv_cnt - d0, 1);
    chk("t2_pdata_good", p_data, 8'h3C);
    send_frame(8'h3C, PRESCALE_16, 1'b1, PAR_EVEN, 1'b1, 1'b1);
    idle(20);
    chk("t2_par_err", pe_cnt - p0, 1);
    chk("t2_no_dv", dv_cnt - d0, 1);
    chk("t2_pdata_held", p_data, 8'h3C);

    // 3: odd parity, stop error then good 0xFF.
    d0 = dv_cnt; p0 = pe_cnt; s0 = se_cnt;
    send_frame(8'h00, PRESCALE_32, 1'b1, PAR_ODD, 1'b1, 1'b0);
    idle(20);
    chk("t3_stp_err", se_cnt - s0, 1);
    chk("t3_no_par", pe_cnt - p0, 0);
    chk("t3_no_dv", dv_cnt - d0, 0);
    send_frame(8'hFF, PRESCALE_32, 1'b1, PAR_ODD, 1'b1, 1'b1);
    idle(20);
    chk("t3_dv_ff", dv_cnt - d0, 1);
    chk("t3_pdata_ff", p_data, 8'hFF);

    // 4: short glitch is rejected, then 0x55.
    d0 = dv_cnt; p0 = pe_cnt; s0 = se_cnt;
    prescale = 6'(PRESCALE_16); par_en = 1'b0;
    drive_bit(1'b0, 5);
    idle(40);
    chk("t4_glitch_quiet", (dv_cnt - d0) + (pe_cnt - p0) + (se_cnt - s0), 0);
    send_frame(8'h55, PRESCALE_16, 1'b0, PAR_EVEN, 1'b0, 1'b1);
    idle(20);
    chk("t4_dv", dv_cnt - d0, 1);
    chk("t4_pdata", p_data, 8'h55);

    // 5: back-to-back frames, no idle gap.
    d0 = dv_cnt;
    send_frame(8'h12, PRESCALE_8, 1'b0, PAR_EVEN, 1'b0, 1'b1);
    send_frame(8'h34, PRESCALE_8, 1'b0, PAR_EVEN, 1'b0, 1'b1);
    idle(20);
    chk("t5_dv_count", dv_cnt - d0, 2);
    chk("t5_spacing", last_dv_cyc - prev_dv_cyc, 80);
    chk("t5_first", prev_dv_data, 8'h12);
    chk("t5_second", p_data, 8'h34);

    // 6: reset during data bit 3 of 0xC3, then 0x81.
    d0 = dv_cnt;
    prescale = 6'(PRESCALE_16); par_en = 1'b0; par_typ = PAR_EVEN;
    d = 8'hC3;
    drive_bit(1'b0, 16);
    for (int i = 0; i < 3; i++) drive_bit(d[i], 16);
    drive_bit(d[3], 8);
    reset = 1'b0;
    rx_in = 1'b1;
    tick(4);
    chk("t6_rst_pdata", p_data, 8'h00);
    chk("t6_rst_flags", {data_valid, par_err, stp_err}, 3'b000);
    reset = 1'b1;
    idle(10);
    send_frame(8'h81, PRESCALE_16, 1'b0, PAR_EVEN, 1'b0, 1'b1);
    idle(20);
    chk("t6_dv", dv_cnt - d0, 1);
    chk("t6_pdata", p_data, 8'h81);

    // Break: line held low well past a frame gives one zero frame with stp_err only.
    d0 = dv_cnt; s0 = se_cnt;
    begin
      ev_t e;
      prescale = 6'(PRESCALE_8); par_en = 1'b0;
      e.cyc = cyc + 3 + 10 * 8; e.dv = 1'b0; e.pe = 1'b0; e.se = 1'b1; e.data = 8'h00;
      q.push_back(e);
      drive_bit(1'b0, 10 * 8 + 40);
      idle(20);
    end
    chk("brk_stp", se_cnt - s0, 1);
    chk("brk_no_dv", dv_cnt - d0, 0);

    // Randomized frames with mixed configs, gaps and injected errors.
    prev_stop_ok = 1'b1; pp = PRESCALE_8; ppe = 1'b0; ppt = 1'b0;
    for (int k = 0; k < 40; k++) begin
      logic pbit, sbit, b2b;
      b2b = prev_stop_ok && ($urandom_range(0, 3) == 0);
      if (b2b) begin
        p = pp; pe = ppe; pt = ppt;
      end else begin
        case ($urandom_range(0, 2))
          0:       p = PRESCALE_8;
          1:       p = PRESCALE_16;
          default: p = PRESCALE_32;
        endcase
        pe = 1'($urandom);
        pt = 1'($urandom);
        idle($urandom_range(2, 12));
      end
      d    = 8'($urandom);
      pbit = good_par(d, pt) ^ ($urandom_range(0, 5) == 0);
      sbit = !($urandom_range(0, 5) == 0);
      send_frame(d, p, pe, pt, pbit, sbit);
      prev_stop_ok = sbit; pp = p; ppe = pe; ppt = pt;
    end
    idle(60);
    chk("events_drained", q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
